// File: rtl/pipe_pkg.sv
// Shared definitions for the write-back pipeline stage: state encoding,
// default widths and the packed entry width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int WB_DATA_W  = 32;
    localparam int WB_RD_W    = 5;
    localparam int WB_ENTRY_W = WB_DATA_W + WB_RD_W + 1;

    // Occupancy is a pure function of the state encoding.
    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        case (s)
            ST_ONE:  state_occupancy = 2'd1;
            ST_FULL: state_occupancy = 2'd2;
            default: state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload register of the write-back stage: load enable plus
// asynchronous active-low clear.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int W = WB_ENTRY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/wb_stage_skid_reg.sv
// MEM->WB pipeline register with a two-entry skid buffer, synchronous flush
// and optional suppression of write-backs aimed at register 0.
module wb_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = WB_DATA_W,
    parameter int RD_W           = WB_RD_W,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic [1:0]        occupancy
);

    localparam int ENTRY_W = DATA_W + RD_W + 1;
    localparam int HEAD    = 0;
    localparam int SKID    = 1;

    pipe_state_e  state_reg;
    pipe_state_e  state_next;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic [1:0]   occupancy_reg;

    logic               in_xfer;
    logic               out_xfer;
    logic               regwrite_guarded;
    logic [ENTRY_W-1:0] in_entry;
    logic [1:0]         entry_load;
    logic [ENTRY_W-1:0] entry_d [2];
    logic [ENTRY_W-1:0] entry_q [2];

    assign in_xfer  = in_valid & in_ready_reg;
    assign out_xfer = out_valid_reg & out_ready;

    // The guard is applied at capture so the stored entry is already clean.
    generate
        if (ZERO_REG_GUARD != 0) begin : g_zero_guard
            assign regwrite_guarded = in_regwrite & (in_rd != '0);
        end else begin : g_no_guard
            assign regwrite_guarded = in_regwrite;
        end
    endgenerate

    assign in_entry = {in_data, in_rd, regwrite_guarded};

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (in_xfer) state_next = ST_ONE;
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_next = ST_FULL;
                    end else if (!in_xfer && out_xfer) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL:  if (out_xfer) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Flush suppresses all loads; stale payload is harmless since out_valid drops.
    always_comb begin
        entry_load    = '0;
        entry_d[HEAD] = in_entry;
        entry_d[SKID] = in_entry;
        if (!flush) begin
            case (state_reg)
                ST_EMPTY: entry_load[HEAD] = in_xfer;
                ST_ONE: begin
                    entry_load[HEAD] = in_xfer & out_xfer;
                    entry_load[SKID] = in_xfer & ~out_xfer;
                end
                ST_FULL: begin
                    entry_load[HEAD] = out_xfer;
                    entry_d[HEAD]    = entry_q[SKID];
                end
                default: entry_load = '0;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            pipe_entry_reg #(
                .W(ENTRY_W)
            ) u_entry (
                .clk  (clk),
                .reset(reset),
                .load (entry_load[gi]),
                .d    (entry_d[gi]),
                .q    (entry_q[gi])
            );
        end
    endgenerate

    // Handshake outputs are registered from the next state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            occupancy_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_FULL);
            out_valid_reg <= (state_next != ST_EMPTY);
            occupancy_reg <= state_occupancy(state_next);
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign occupancy    = occupancy_reg;
    assign out_data     = entry_q[HEAD][ENTRY_W-1 -: DATA_W];
    assign out_rd       = entry_q[HEAD][RD_W:1];
    assign out_regwrite = out_valid_reg & entry_q[HEAD][0];

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Directed self-checking bench for wb_stage_skid_reg; a second instance with
// the zero-register guard disabled shares the same stimulus.
`timescale 1ns/1ps
module tb_wb_stage_skid_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic [1:0]  occupancy;

    logic        ng_in_ready;
    logic        ng_out_valid;
    logic [31:0] ng_out_data;
    logic [4:0]  ng_out_rd;
    logic        ng_out_regwrite;
    logic [1:0]  ng_occupancy;

    int pass_count;
    int check_count;

    wb_stage_skid_reg #(.DATA_W(32), .RD_W(5), .ZERO_REG_GUARD(1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .occupancy(occupancy)
    );

    wb_stage_skid_reg #(.DATA_W(32), .RD_W(5), .ZERO_REG_GUARD(0)) u_dut_ng (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ng_in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
        .out_valid(ng_out_valid), .out_ready(out_ready), .out_data(ng_out_data),
        .out_rd(ng_out_rd), .out_regwrite(ng_out_regwrite), .occupancy(ng_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic rw);
        in_valid    = v;
        in_data     = d;
        in_rd       = rd;
        in_regwrite = rw;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        flush = 1'b0;
        out_ready = 1'b1;
        #12;
        check_count++;
        if ({out_valid, out_regwrite, in_ready, occupancy} !== 5'b00_1_00)
            $display("FAIL reset_ctrl: got v=%b rw=%b rdy=%b occ=%0d want v=0 rw=0 rdy=1 occ=0",
                     out_valid, out_regwrite, in_ready, occupancy);
        else pass_count++;
        check_count++;
        if (out_data !== 32'h0 || out_rd !== 5'd0)
            $display("FAIL reset_payload: got data=%h rd=%0d want 0/0", out_data, out_rd);
        else pass_count++;
        tick();
        reset = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_single_push();
        out_ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        $display("push data=deadbeef rd=7 -> out data=%h rd=%0d", out_data, out_rd);
        check_count++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_rd !== 5'd7)
            $display("FAIL single_push: got v=%b data=%h rd=%0d want 1/deadbeef/7", out_valid, out_data, out_rd);
        else pass_count++;
        check_count++;
        if (out_regwrite !== 1'b1 || occupancy !== 2'd1)
            $display("FAIL single_push_rw: got rw=%b occ=%0d want 1/1", out_regwrite, occupancy);
        else pass_count++;
        tick();
        check_count++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL single_pop: got v=%b occ=%0d want 0/0", out_valid, occupancy);
        else pass_count++;
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd1, 1'b1);
        tick();
        drive(1'b1, 32'h22, 5'd2, 1'b1);
        tick();
        $display("push 11, 22 with out_ready=0 -> occ=%0d", occupancy);
        check_count++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11)
            $display("FAIL skid_full: got occ=%0d rdy=%b data=%h want 2/0/11", occupancy, in_ready, out_data);
        else pass_count++;
        drive(1'b1, 32'h33, 5'd3, 1'b1);
        tick();
        $display("push 33 while full -> occ=%0d head=%h", occupancy, out_data);
        check_count++;
        if (occupancy !== 2'd2 || out_data !== 32'h11 || out_rd !== 5'd1 || out_regwrite !== 1'b1)
            $display("FAIL skid_refuse_hold: got occ=%0d data=%h rd=%0d rw=%b want 2/11/1/1",
                     occupancy, out_data, out_rd, out_regwrite);
        else pass_count++;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        $display("pop -> head=%h", out_data);
        check_count++;
        if (out_data !== 32'h22 || out_rd !== 5'd2 || in_ready !== 1'b1 || occupancy !== 2'd1)
            $display("FAIL skid_drain1: got data=%h rd=%0d rdy=%b occ=%0d want 22/2/1/1",
                     out_data, out_rd, in_ready, occupancy);
        else pass_count++;
        tick();
        check_count++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL skid_drain2: got v=%b occ=%0d want 0/0", out_valid, occupancy);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 5'(i + 1), 1'b1);
            tick();
            $display("stream %0d -> out data=%h occ=%0d", i, out_data, occupancy);
            check_count++;
            if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'(i) || out_rd !== 5'(i + 1)
                || occupancy !== 2'd1 || in_ready !== 1'b1)
                $display("FAIL stream_%0d: got v=%b data=%h rd=%0d occ=%0d rdy=%b want 1/%h/%0d/1/1",
                         i, out_valid, out_data, out_rd, occupancy, in_ready, 32'h100 + 32'(i), i + 1);
            else pass_count++;
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check_count++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL stream_end: got v=%b occ=%0d want 0/0", out_valid, occupancy);
        else pass_count++;
    endtask

    task automatic test_zero_guard();
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 5'd0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        $display("push rd=0 data=55 -> guard rw=%b noguard rw=%b", out_regwrite, ng_out_regwrite);
        check_count++;
        if (out_valid !== 1'b1 || out_regwrite !== 1'b0 || out_data !== 32'h55)
            $display("FAIL zero_guard: got v=%b rw=%b data=%h want 1/0/55", out_valid, out_regwrite, out_data);
        else pass_count++;
        check_count++;
        if (ng_out_valid !== 1'b1 || ng_out_regwrite !== 1'b1)
            $display("FAIL zero_noguard: got v=%b rw=%b want 1/1", ng_out_valid, ng_out_regwrite);
        else pass_count++;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 5'd4, 1'b1);
        tick();
        drive(1'b1, 32'hA2, 5'd5, 1'b1);
        tick();
        drive(1'b1, 32'h77, 5'd6, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        $display("flush with push 77 -> occ=%0d v=%b", occupancy, out_valid);
        check_count++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_regwrite !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush: got occ=%0d v=%b rw=%b rdy=%b want 0/0/0/1",
                     occupancy, out_valid, out_regwrite, in_ready);
        else pass_count++;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_count++;
            if (out_valid !== 1'b0 || out_regwrite !== 1'b0)
                $display("FAIL flush_drop_%0d: got v=%b data=%h want v=0", i, out_valid, out_data);
            else pass_count++;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'hB1, 5'd8, 1'b1);
        tick();
        drive(1'b1, 32'hB2, 5'd9, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check_count++;
        if (occupancy !== 2'd2)
            $display("FAIL async_pre_full: got occ=%0d want 2", occupancy);
        else pass_count++;
        #2;
        reset = 1'b0;
        #1;
        $display("async reset mid-cycle -> v=%b occ=%0d", out_valid, occupancy);
        check_count++;
        if ({out_valid, out_regwrite, in_ready, occupancy} !== 5'b00_1_00
            || out_data !== 32'h0 || out_rd !== 5'd0)
            $display("FAIL async_reset: got v=%b rw=%b rdy=%b occ=%0d data=%h rd=%0d want 0/0/1/0/0/0",
                     out_valid, out_regwrite, in_ready, occupancy, out_data, out_rd);
        else pass_count++;
        #2;
        reset = 1'b1;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 32'hC3, 5'd3, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        $display("push c3 after reset -> out data=%h", out_data);
        check_count++;
        if (out_valid !== 1'b1 || out_data !== 32'hC3 || out_rd !== 5'd3 || occupancy !== 2'd1)
            $display("FAIL post_reset_push: got v=%b data=%h rd=%0d occ=%0d want 1/c3/3/1",
                     out_valid, out_data, out_rd, occupancy);
        else pass_count++;
        tick();
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        test_reset();
        test_single_push();
        test_skid();
        test_back_to_back();
        test_zero_guard();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
